// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared constants and types for the instruction fetch stage.
//   - NOP_INSTR      : canonical no-op (addi x0,x0,0) shown on o_instr when
//                      the fetch buffer holds nothing
//   - fetch_state_e  : fetch FSM states (BOOT / RUN / FLUSH)
//   - align_word()   : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// ---------------------------------------------------------------------------
// fetch_unit_fifo
//   Small synchronous FIFO used twice by fetch_unit: once as the {pc,instr}
//   fetch buffer and once as the in-order PC tag queue for outstanding
//   requests. Head data is visible combinationally from the entry registers
//   so a word pushed at edge N is presented in cycle N+1.
//   DEPTH must be a power of two (pointers wrap naturally).
// Ports
//   i_clk / i_rst_n : clock, synchronous active-low reset
//   i_push, i_data  : write request and data
//   i_pop           : read request (ignored when empty)
//   i_flush         : empties the FIFO; wins over push and pop
//   o_data          : head entry
//   o_full, o_empty, o_count : occupancy
// ---------------------------------------------------------------------------
module fetch_unit_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] entry_data [DEPTH];

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_count = count_q;

  assign do_pop  = i_pop && !o_empty && !i_flush;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push = i_push && !i_flush && (!o_full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset: occupancy alone decides what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge i_clk) begin
      if (do_push && (wr_ptr_q == AW'(gi))) begin
        data_q <= i_data;
      end
    end
    assign entry_data[gi] = data_q;
  end

  assign o_data = entry_data[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the fetch PC, issues word-aligned requests
//   on the instruction-memory port, tags each request with its PC in an
//   in-order tag queue, and buffers returned words as {pc,instr} for decode.
//   A branch redirect flushes the buffer and marks every request still in
//   flight for discard so no wrong-path word ever reaches decode.
// Parameters
//   RESET_PC    fetch address after reset
//   FIFO_DEPTH  fetch-buffer entries and max requests in flight (pow2, >=2)
// Ports
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   o_imem_req, o_imem_addr        request valid / word address
//   i_imem_gnt                     request accepted (req & gnt)
//   i_imem_rvalid, i_imem_rdata    in-order response
//   i_b_taken, i_b_pc              redirect pulse and target
//   o_valid, o_pc, o_instr         head of fetch buffer to decode
//   i_ready                        decode accepts (o_valid & i_ready = pop)
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_b_taken,
  input  logic [31:0] i_b_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  input  logic        i_ready
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          gnt_fire;
  logic          rsp;
  logic          buf_push;
  logic          buf_pop;
  logic          buf_empty;
  logic          buf_full;
  logic [CW-1:0] buf_count;
  logic [63:0]   buf_head;
  logic [31:0]   tag_head;
  logic          tag_empty;
  logic          tag_full;
  logic [CW-1:0] tag_count;
  logic [CW:0]   credit_used;

  // -------------------------------------------------------------------------
  // Issue
  // -------------------------------------------------------------------------
  assign buf_pop = !buf_empty && i_ready;

  // Every slot is either buffered or in flight; a pop this cycle frees one.
  // Once this is true it stays true until the grant (responses only move a
  // slot from in-flight to buffered), so req/addr stay stable while stalled.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, buf_count}
                     - (CW+1)'(buf_pop);
  assign o_imem_req  = (state_q != ST_BOOT) && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign o_imem_addr = fetch_pc_q;

  assign gnt_fire = o_imem_req && i_imem_gnt;
  assign rsp      = i_imem_rvalid;

  // Responses owed to a redirected-away path are dropped; nothing is pushed
  // in a redirect cycle because the buffer is being flushed.
  assign buf_push = rsp && (discard_q == '0) && !i_b_taken;

  // -------------------------------------------------------------------------
  // Next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (gnt_fire && !rsp) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!gnt_fire && rsp) begin
      outstanding_d = outstanding_q - CW'(1);
    end

    if (i_b_taken) begin
      fetch_pc_d = align_word(i_b_pc);
      // Everything still in flight after this edge belongs to the old path,
      // including a request granted in this very cycle.
      discard_d  = outstanding_d;
    end else begin
      if (gnt_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        if (i_b_taken) begin
          state_d = (discard_d != '0) ? ST_FLUSH : ST_RUN;
        end else if ((state_q == ST_FLUSH) && (discard_d == '0)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // -------------------------------------------------------------------------
  // Tag queue: PC of each granted request, consumed by its response
  // -------------------------------------------------------------------------
  fetch_unit_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_q (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (gnt_fire),
    .i_data  (fetch_pc_q),
    .i_pop   (rsp),
    .i_flush (1'b0),
    .o_data  (tag_head),
    .o_full  (tag_full),
    .o_empty (tag_empty),
    .o_count (tag_count)
  );

  // -------------------------------------------------------------------------
  // Fetch buffer: {pc, instr} towards decode
  // -------------------------------------------------------------------------
  fetch_unit_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (buf_push),
    .i_data  ({tag_head, i_imem_rdata}),
    .i_pop   (buf_pop),
    .i_flush (i_b_taken),
    .o_data  (buf_head),
    .o_full  (buf_full),
    .o_empty (buf_empty),
    .o_count (buf_count)
  );

  assign o_valid = !buf_empty;
  assign o_pc    = buf_empty ? RESET_PC  : buf_head[63:32];
  assign o_instr = buf_empty ? NOP_INSTR : buf_head[31:0];

  // -------------------------------------------------------------------------
  // Protocol and consistency checks
  // -------------------------------------------------------------------------
  a_rvalid_needs_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    rsp |-> (outstanding_q != '0) && !tag_empty);

  a_tags_track_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    tag_count == outstanding_q);

  a_no_grant_when_tags_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    gnt_fire |-> !tag_full || rsp);

  a_no_buffer_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    buf_push |-> !buf_full || buf_pop);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_b_taken;
  logic [31:0] i_b_pc;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_b_taken     (i_b_taken),
    .i_b_pc        (i_b_pc),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .i_ready       (i_ready)
  );

  int tests = 0;
  int fails = 0;

  // Memory contents: every address holds a distinct, easily predicted word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rv_addr;
    logic        taken;
    logic [31:0] bpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rv_addr,
                              input logic taken, input logic [31:0] bpc, input logic ready,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rv_addr = rv_addr; v.taken = taken; v.bpc = bpc;
    v.ready = ready; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  // Called just after a falling edge: drive, settle, compare, advance one cycle.
  task automatic run_vec(input vec_t v, input string tag);
    i_imem_gnt    = v.gnt;
    i_imem_rvalid = v.rv;
    i_imem_rdata  = v.rv ? mem_word(v.rv_addr) : 32'hDEAD_BEEF;
    i_b_taken     = v.taken;
    i_b_pc        = v.bpc;
    i_ready       = v.ready;
    #1;
    check({tag, ".req"}, {31'b0, o_imem_req}, {31'b0, v.e_req});
    if (v.e_req) check({tag, ".addr"}, o_imem_addr, v.e_addr);
    check({tag, ".valid"}, {31'b0, o_valid}, {31'b0, v.e_valid});
    if (v.e_valid) begin
      check({tag, ".pc"}, o_pc, v.e_pc);
      check({tag, ".instr"}, o_instr, mem_word(v.e_pc));
    end
    $display("[TB] %s req=%0b addr=%08h valid=%0b pc=%08h instr=%08h",
             tag, o_imem_req, o_imem_addr, o_valid, o_pc, o_instr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req"},   {31'b0, o_imem_req}, 32'd0);
    check({tag, ".valid"}, {31'b0, o_valid},    32'd0);
    check({tag, ".pc"},    o_pc,                RESET_PC);
    check({tag, ".instr"}, o_instr,             NOP_INSTR);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  vec_t  vecs[$];
  mreq_t mq[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Streaming with 1-cycle memory, a grant stall and decode back-pressure.
    //             gnt rv  rv_addr   tk bpc ry  req addr     vld pc
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 32'h00)); // BOOT
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 1,  1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(1, 1, 32'h00, 0, 0, 1,  1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(1, 1, 32'h04, 0, 0, 1,  1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(1, 1, 32'h08, 0, 0, 1,  1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 1, 32'h0C, 0, 0, 1,  1, 32'h10, 1, 32'h08));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,  1, 32'h10, 1, 32'h0C));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,  1, 32'h10, 0, 32'h00));
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 1,  1, 32'h10, 0, 32'h00));
    vecs.push_back(mk(0, 1, 32'h10, 0, 0, 1,  1, 32'h14, 0, 32'h00));
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 0,  1, 32'h14, 1, 32'h10));
    vecs.push_back(mk(1, 1, 32'h14, 0, 0, 0,  0, 32'h00, 1, 32'h10));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 32'h10)); // buffer full
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 1,  1, 32'h18, 1, 32'h10));
    vecs.push_back(mk(0, 1, 32'h18, 0, 0, 1,  1, 32'h1C, 1, 32'h14));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,  1, 32'h1C, 1, 32'h18));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,  1, 32'h1C, 0, 32'h00));

    rst_n = 1'b0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_b_taken = 1'b0; i_b_pc = '0; i_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Redirect to 0x100 with two requests in flight: both responses dropped.
    run_vec(mk(1, 0, 32'h000, 0, 32'h000, 1,  1, 32'h01C, 0, 0), "rd1");
    run_vec(mk(1, 0, 32'h000, 0, 32'h000, 1,  1, 32'h020, 0, 0), "rd2");
    run_vec(mk(0, 0, 32'h000, 1, 32'h100, 1,  0, 32'h000, 0, 0), "rd3");
    check("rd4.flush_state", {30'b0, dut.state_q}, {30'b0, ST_FLUSH});
    run_vec(mk(1, 1, 32'h01C, 0, 32'h000, 1,  0, 32'h000, 0, 0), "rd4");
    run_vec(mk(1, 1, 32'h020, 0, 32'h000, 1,  1, 32'h100, 0, 0), "rd5");
    run_vec(mk(0, 1, 32'h100, 0, 32'h000, 1,  1, 32'h104, 0, 0), "rd6");
    run_vec(mk(0, 0, 32'h000, 0, 32'h000, 1,  1, 32'h104, 1, 32'h100), "rd7");

    // Grant withheld three cycles, redirect (unaligned target) during the stall.
    run_vec(mk(0, 0, 32'h000, 0, 32'h000, 1,  1, 32'h104, 0, 0), "st1");
    run_vec(mk(0, 0, 32'h000, 0, 32'h000, 1,  1, 32'h104, 0, 0), "st2");
    run_vec(mk(0, 0, 32'h000, 1, 32'h203, 1,  1, 32'h104, 0, 0), "st3");
    run_vec(mk(1, 0, 32'h000, 0, 32'h000, 1,  1, 32'h200, 0, 0), "st4");
    run_vec(mk(0, 1, 32'h200, 0, 32'h000, 1,  1, 32'h204, 0, 0), "st5");
    run_vec(mk(0, 0, 32'h000, 0, 32'h000, 1,  1, 32'h204, 1, 32'h200), "st6");

    // Redirect, grant and response all in one cycle; target 0x103 -> 0x100.
    run_vec(mk(1, 0, 32'h000, 0, 32'h000, 1,  1, 32'h204, 0, 0), "sc1");
    run_vec(mk(1, 1, 32'h204, 1, 32'h103, 1,  1, 32'h208, 0, 0), "sc2");
    check("sc3.flush_state", {30'b0, dut.state_q}, {30'b0, ST_FLUSH});
    run_vec(mk(1, 1, 32'h208, 0, 32'h000, 1,  1, 32'h100, 0, 0), "sc3");
    run_vec(mk(0, 1, 32'h100, 0, 32'h000, 1,  1, 32'h104, 0, 0), "sc4");
    run_vec(mk(0, 0, 32'h000, 0, 32'h000, 1,  1, 32'h104, 1, 32'h100), "sc5");

    // Fetch PC wraps from 0xFFFF_FFFC to 0.
    run_vec(mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1,  1, 32'h104,       0, 0), "wr1");
    run_vec(mk(1, 0, 32'h0,         0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 0), "wr2");
    run_vec(mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,         1,  1, 32'h0000_0000, 0, 0), "wr3");
    run_vec(mk(1, 0, 32'h0,         0, 32'h0,         1,  1, 32'h0000_0000, 1, 32'hFFFF_FFFC), "wr4");

    // Reset with a request still in flight.
    rst_n = 1'b0;
    i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_b_taken = 1'b0; i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;

    // Randomized run against a program-order model: decode must see a
    // sequential stream restarting at each redirect target, nothing else.
    begin
      logic [31:0] exp_pc;
      logic [31:0] tgt;
      logic [31:0] prev_addr;
      logic        prev_hold;
      int          pops;
      int          redirects;
      exp_pc    = RESET_PC;
      prev_hold = 1'b0;
      prev_addr = '0;
      pops      = 0;
      redirects = 0;
      mq.delete();
      for (int c = 0; c < 4000; c++) begin
        i_ready    = ($urandom_range(0, 3) != 0);
        i_imem_gnt = ($urandom_range(0, 2) != 0);
        if (mq.size() > 0 && mq[0].due <= c) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_word(mq[0].addr);
        end else begin
          i_imem_rvalid = 1'b0;
          i_imem_rdata  = 32'hDEAD_BEEF;
        end
        i_b_taken = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        else                           tgt = $urandom_range(0, 32'h3FF);
        i_b_pc = tgt;
        #1;
        if (prev_hold) begin
          check("rand.req_hold",  {31'b0, o_imem_req}, 32'd1);
          check("rand.addr_hold", o_imem_addr, prev_addr);
        end
        if (o_valid && i_ready) begin
          check("rand.pc", o_pc, exp_pc);
          check("rand.instr", o_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          pops++;
        end
        if (i_b_taken) begin
          exp_pc = tgt & 32'hFFFF_FFFC;
          redirects++;
        end
        if (i_imem_rvalid) void'(mq.pop_front());
        if (o_imem_req && i_imem_gnt) begin
          mreq_t m;
          check("rand.addr_align", {30'b0, o_imem_addr[1:0]}, 32'd0);
          m.addr = o_imem_addr;
          m.due  = c + 1 + int'($urandom_range(0, 3));
          mq.push_back(m);
        end
        check("rand.inflight_bound", (mq.size() <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        prev_hold = o_imem_req && !i_imem_gnt && !i_b_taken;
        prev_addr = o_imem_addr;
        @(posedge clk);
        @(negedge clk);
      end
      $display("[TB] random phase: %0d words delivered, %0d redirects", pops, redirects);
      check("rand.progress", (pops >= 300) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
